bram_port_arbiter: RTL and testbench
====================================

BRAM_PORT_ARBITER -- requirements
Module: bram_port_arbiter

Interface
REQ-001 The block SHALL have parameter ADDR_W, default 17, meaning BRAM address width.
REQ-002 The block SHALL have parameter DATA_W, default 12, meaning pixel width (RGB444).
REQ-003 The block SHALL have parameter FIFO_DEPTH, default 4, meaning write-buffer entries (power of two).
REQ-004 The block SHALL have parameter FRAME_PIXELS, default 76800, meaning pixels per frame (320x240).
REQ-005 The block SHALL have port clk, input, 1, meaning the single system clock; all logic is rising-edge.
REQ-006 The block SHALL have port rst, input, 1, meaning asynchronous active-low reset.
REQ-007 The block SHALL have port wr_addr, input, ADDR_W, meaning write-requester address.
REQ-008 The block SHALL have port wr_data, input, DATA_W, meaning write-requester pixel.
REQ-009 The block SHALL have port wr_en, input, 1, meaning write request.
REQ-010 The block SHALL have port wr_ready, output, 1, meaning FIFO not full.
REQ-011 The block SHALL have port rd_addr, input, ADDR_W, meaning display read address.
REQ-012 The block SHALL have port rd_en, input, 1, meaning display read request.
REQ-013 The block SHALL have port rd_data, output, DATA_W, meaning read pixel.
REQ-014 The block SHALL have port rd_valid, output, 1, meaning rd_data valid.
REQ-015 The block SHALL have ports bram_addr (ADDR_W), bram_din (DATA_W), bram_we (1) and bram_en (1), all outputs, meaning the single-port BRAM drive.
REQ-016 The block SHALL have port bram_dout, input, DATA_W, meaning BRAM read data (1-cycle latency).
REQ-017 The block SHALL have port fifo_level, output, log2(FIFO_DEPTH)+1, meaning write-FIFO occupancy.
REQ-018 The block SHALL have port ovf, output, 1, meaning sticky write-drop flag.
REQ-019 The block SHALL have port frame_done, output, 1, meaning one-cycle pulse when address FRAME_PIXELS-1 is committed to BRAM.

Function
REQ-020 The block SHALL accept a write (push) when wr_en=1 and wr_ready=1 at a rising edge.
REQ-021 The block SHALL drop a write when wr_en=1 and the FIFO is full, keep all contents unchanged, and set ovf.
REQ-022 The block SHALL implement arbiter states IDLE, RD and WR, re-evaluated every cycle: rd_en=1 -> RD; else FIFO non-empty -> WR; else IDLE.
REQ-023 Reads SHALL have absolute priority; while rd_en=1 no FIFO entry is popped.
REQ-024 In RD the block SHALL register bram_en=1, bram_we=0 and bram_addr=rd_addr.
REQ-025 In WR the block SHALL pop the FIFO head and register bram_en=1, bram_we=1, bram_addr and bram_din from that head.
REQ-026 In IDLE the block SHALL register bram_en=0 and bram_we=0; bram_addr and bram_din hold their values.
REQ-027 Read latency SHALL be exactly 2 cycles: rd_en sampled at edge k gives rd_valid=1 and rd_data=bram_dout after edge k+2.
REQ-028 Back-to-back reads SHALL give one rd_valid per cycle.
REQ-029 A push and a pop in the same cycle SHALL leave fifo_level unchanged; a push to a full FIFO SHALL be dropped even if a pop occurs in that cycle.
REQ-030 Writes SHALL commit to BRAM in push order; FIFO pointers SHALL wrap modulo FIFO_DEPTH.
REQ-031 frame_done SHALL pulse in the cycle bram_we=1 with bram_addr=FRAME_PIXELS-1.
REQ-032 A read and a write to the same address at the same time SHALL return the old BRAM contents (no forwarding).

Reset
REQ-033 While rst=0, the block SHALL asynchronously force: bram_en, bram_we, rd_valid, ovf and frame_done to 0; bram_addr, bram_din and rd_data to 0; FIFO empty (fifo_level=0, wr_ready=1); state IDLE.
REQ-034 Assertion of rst mid-operation SHALL discard pending FIFO entries and in-flight reads; no rd_valid SHALL follow release.
REQ-035 ovf SHALL clear only on reset.

Structure
REQ-036 ADDR_W, DATA_W, FRAME_PIXELS and the state encoding SHALL live in shared package video_pkg.
REQ-037 The write buffer SHALL be a sub-module sync_fifo (push/pop/full/empty/level).

Verification
REQ-038 The bench SHALL cover: writes 0xAA1/0xAA2/0xAA3 to addresses 0/1/2 with rd_en=0 -> bram_we pulses at addresses 0,1,2 with data AA1,AA2,AA3 in order.
REQ-039 The bench SHALL cover: rd_en=1 for 8 cycles while 6 writes arrive -> 4 accepted, 2 dropped, ovf=1, and no bram_we until rd_en falls; then 4 writes drain on consecutive cycles.
REQ-040 The bench SHALL cover: preloaded address 5=0x123 and rd_en with rd_addr=5 at edge k -> rd_valid=1 and rd_data=0x123 after edge k+2.
REQ-041 The bench SHALL cover: simultaneous push/pop with fifo_level=2 -> level stays 2, with order preserved across pointer wrap after 10 writes.
REQ-042 The bench SHALL cover: write to address 76799 -> frame_done single-cycle pulse coincident with bram_we.
REQ-043 The bench SHALL cover: rst=0 with 3 entries queued and 1 read in flight -> fifo_level=0, no bram_we and no rd_valid after release.

Source files
------------

// File: rtl/video_pkg.sv
// Shared video-path constants and the BRAM arbiter state encoding.
package video_pkg;
    localparam int ADDR_W       = 17;
    localparam int DATA_W       = 12;
    localparam int FRAME_PIXELS = 76800;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RD   = 2'd1,
        ST_WR   = 2'd2
    } arb_state_t;
endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with occupancy count; pushes while full are ignored.
module sync_fifo #(
    parameter int W     = 29,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     i_push,
    input  logic                     i_pop,
    input  logic [W-1:0]             i_data,
    output logic [W-1:0]             o_data,
    output logic                     o_full,
    output logic                     o_empty,
    output logic [$clog2(DEPTH):0]   o_level
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int LVL_W = PTR_W + 1;

    logic [W-1:0]     r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [LVL_W-1:0] r_level;
    logic             w_push_ok;
    logic             w_pop_ok;

    // Full is judged on the registered level, so a same-cycle pop cannot admit a push.
    assign o_full    = (r_level == LVL_W'(DEPTH));
    assign o_empty   = (r_level == '0);
    assign w_push_ok = i_push && !o_full;
    assign w_pop_ok  = i_pop && !o_empty;
    assign o_data    = r_mem[r_rd_ptr];
    assign o_level   = r_level;

    always_ff @(posedge clk) begin
        if (w_push_ok) r_mem[r_wr_ptr] <= i_data;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else begin
            if (w_push_ok) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            if (w_pop_ok)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            case ({w_push_ok, w_pop_ok})
                2'b10:   r_level <= r_level + LVL_W'(1);
                2'b01:   r_level <= r_level - LVL_W'(1);
                default: ;
            endcase
        end
    end
endmodule

// File: rtl/bram_port_arbiter.sv
// Shares one single-port BRAM between a display reader (priority) and a buffered pixel writer.
//   state   | meaning
//   ST_IDLE | BRAM disabled, address/data held
//   ST_RD   | display read issued at rd_addr
//   ST_WR   | FIFO head committed to BRAM
module bram_port_arbiter #(
    parameter int ADDR_W       = video_pkg::ADDR_W,
    parameter int DATA_W       = video_pkg::DATA_W,
    parameter int FIFO_DEPTH   = 4,
    parameter int FRAME_PIXELS = video_pkg::FRAME_PIXELS
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [ADDR_W-1:0]             wr_addr,
    input  logic [DATA_W-1:0]             wr_data,
    input  logic                          wr_en,
    output logic                          wr_ready,
    input  logic [ADDR_W-1:0]             rd_addr,
    input  logic                          rd_en,
    output logic [DATA_W-1:0]             rd_data,
    output logic                          rd_valid,
    output logic [ADDR_W-1:0]             bram_addr,
    output logic [DATA_W-1:0]             bram_din,
    output logic                          bram_we,
    output logic                          bram_en,
    input  logic [DATA_W-1:0]             bram_dout,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
    output logic                          ovf,
    output logic                          frame_done
);
    import video_pkg::*;

    arb_state_t                 r_state;
    arb_state_t                 w_next;
    logic                       w_full;
    logic                       w_empty;
    logic                       w_pop;
    logic [ADDR_W+DATA_W-1:0]   w_head;
    logic [ADDR_W-1:0]          w_head_addr;
    logic [DATA_W-1:0]          w_head_data;
    logic [ADDR_W-1:0]          r_bram_addr;
    logic [DATA_W-1:0]          r_bram_din;
    logic [DATA_W-1:0]          r_rd_data;
    logic                       r_rd_pend;
    logic                       r_rd_valid;
    logic                       r_frame_done;
    logic                       r_ovf;

    sync_fifo #(
        .W     (ADDR_W + DATA_W),
        .DEPTH (FIFO_DEPTH)
    ) u_wr_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_push  (wr_en),
        .i_pop   (w_pop),
        .i_data  ({wr_addr, wr_data}),
        .o_data  (w_head),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_level (fifo_level)
    );

    assign w_head_addr = w_head[ADDR_W+DATA_W-1:DATA_W];
    assign w_head_data = w_head[DATA_W-1:0];

    always_comb begin
        w_next = ST_IDLE;
        if (rd_en)         w_next = ST_RD;
        else if (!w_empty) w_next = ST_WR;
    end

    assign w_pop = (w_next == ST_WR);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) r_state <= ST_IDLE;
        else      r_state <= w_next;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_bram_addr  <= '0;
            r_bram_din   <= '0;
            r_rd_data    <= '0;
            r_rd_pend    <= 1'b0;
            r_rd_valid   <= 1'b0;
            r_frame_done <= 1'b0;
            r_ovf        <= 1'b0;
        end else begin
            case (w_next)
                ST_RD: r_bram_addr <= rd_addr;
                ST_WR: begin
                    r_bram_addr <= w_head_addr;
                    r_bram_din  <= w_head_data;
                end
                default: ;
            endcase
            r_frame_done <= (w_next == ST_WR) && (w_head_addr == ADDR_W'(FRAME_PIXELS - 1));
            // BRAM returns data one cycle after the RD cycle; capture it one cycle later.
            r_rd_pend  <= (r_state == ST_RD);
            r_rd_valid <= r_rd_pend;
            if (r_rd_pend) r_rd_data <= bram_dout;
            if (wr_en && w_full) r_ovf <= 1'b1;
        end
    end

    assign bram_en    = (r_state != ST_IDLE);
    assign bram_we    = (r_state == ST_WR);
    assign bram_addr  = r_bram_addr;
    assign bram_din   = r_bram_din;
    assign rd_data    = r_rd_data;
    assign rd_valid   = r_rd_valid;
    assign wr_ready   = !w_full;
    assign ovf        = r_ovf;
    assign frame_done = r_frame_done;
endmodule

// File: tb/tb_bram_port_arbiter.sv
// Bench for bram_port_arbiter: BRAM model, queue-based reference model, directed and random stimulus.
`timescale 1ns/1ps
module tb_bram_port_arbiter;
    localparam int AW    = 17;
    localparam int DW    = 12;
    localparam int DEPTH = 4;
    localparam int FP    = 76800;
    localparam int LW    = 3;
    localparam int MAXC  = 8192;

    logic          clk = 1'b0;
    logic          rst;
    logic [AW-1:0] wr_addr, rd_addr, bram_addr;
    logic [DW-1:0] wr_data, rd_data, bram_din, bram_dout;
    logic          wr_en, rd_en, wr_ready, rd_valid, bram_we, bram_en, ovf, frame_done;
    logic [LW-1:0] fifo_level;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    bram_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .FIFO_DEPTH(DEPTH), .FRAME_PIXELS(FP)) dut (
        .clk(clk), .rst(rst),
        .wr_addr(wr_addr), .wr_data(wr_data), .wr_en(wr_en), .wr_ready(wr_ready),
        .rd_addr(rd_addr), .rd_en(rd_en), .rd_data(rd_data), .rd_valid(rd_valid),
        .bram_addr(bram_addr), .bram_din(bram_din), .bram_we(bram_we), .bram_en(bram_en),
        .bram_dout(bram_dout), .fifo_level(fifo_level), .ovf(ovf), .frame_done(frame_done)
    );

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic [63:0] pk(input logic [AW-1:0] a, input logic [DW-1:0] d);
        return {35'd0, a, d};
    endfunction

    // Single-port BRAM with one-cycle read latency
    logic [DW-1:0] mem [0:(1<<AW)-1];
    always @(posedge clk) begin
        if (bram_en) begin
            if (bram_we) mem[bram_addr] = bram_din;
            else         bram_dout <= mem[bram_addr];
        end
    end

    // Reference model: pending writes as a queue, reads resolved against model memory by cycle index
    typedef struct packed { logic [AW-1:0] a; logic [DW-1:0] d; } wr_t;
    logic [DW-1:0] ref_mem [0:(1<<AW)-1];
    wr_t           mq[$];
    wr_t           m_head, m_pc;
    bit            m_pc_v, m_full;
    int            cyc = 0, last_rst_cyc = 0;
    bit            hv [MAXC];
    logic [DW-1:0] hd [MAXC];
    logic          e_en, e_we, e_fd, e_ovf, e_rv;
    logic [AW-1:0] e_addr;
    logic [DW-1:0] e_din, e_rd;

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            mq.delete();
            m_pc_v = 1'b0;
            last_rst_cyc = cyc;
            e_en = 0; e_we = 0; e_fd = 0; e_ovf = 0; e_rv = 0;
            e_addr = '0; e_din = '0; e_rd = '0;
        end else begin
            cyc++;
            if (m_pc_v) ref_mem[m_pc.a] = m_pc.d;
            m_pc_v = 1'b0;
            m_full = (mq.size() == DEPTH);
            e_fd = 1'b0;
            hv[cyc] = 1'b0;
            if (rd_en) begin
                e_en = 1; e_we = 0; e_addr = rd_addr;
                hv[cyc] = 1'b1;
                hd[cyc] = ref_mem[rd_addr];
            end else if (mq.size() > 0) begin
                m_head = mq.pop_front();
                e_en = 1; e_we = 1; e_addr = m_head.a; e_din = m_head.d;
                e_fd = (int'(m_head.a) == FP - 1);
                m_pc = m_head; m_pc_v = 1'b1;
            end else begin
                e_en = 0; e_we = 0;
            end
            if (wr_en) begin
                if (m_full) e_ovf = 1'b1;
                else        mq.push_back({wr_addr, wr_data});
            end
            if ((cyc - 2) > last_rst_cyc && hv[cyc-2]) begin
                e_rv = 1'b1; e_rd = hd[cyc-2];
            end else begin
                e_rv = 1'b0;
            end
        end
    end

    always @(negedge clk) begin
        chk("bram_en",    bram_en,    e_en);
        chk("bram_we",    bram_we,    e_we);
        chk("bram_addr",  bram_addr,  e_addr);
        chk("bram_din",   bram_din,   e_din);
        chk("frame_done", frame_done, e_fd);
        chk("ovf",        ovf,        e_ovf);
        chk("rd_valid",   rd_valid,   e_rv);
        chk("rd_data",    rd_data,    e_rd);
        chk("fifo_level", fifo_level, mq.size());
        chk("wr_ready",   wr_ready,   mq.size() < DEPTH);
    end

    // Event log sampled just after each edge, used by the directed checks
    typedef struct { logic [AW-1:0] a; logic [DW-1:0] d; int c; } log_t;
    log_t we_log[$];
    int   mcyc = 0, fd_cnt = 0, fd_ok = 0, rv_cnt = 0;
    always @(posedge clk) begin
        #1;
        mcyc++;
        if (bram_we === 1'b1) we_log.push_back('{a: bram_addr, d: bram_din, c: mcyc});
        if (frame_done === 1'b1) begin
            fd_cnt++;
            if (bram_we === 1'b1 && int'(bram_addr) == FP - 1) fd_ok++;
        end
        if (rd_valid === 1'b1) rv_cnt++;
    end

    initial begin
        for (int i = 0; i < (1 << AW); i++) begin
            mem[i]     = DW'(i * 7 + 3);
            ref_mem[i] = DW'(i * 7 + 3);
        end
        mem[5] = 12'h123; ref_mem[5] = 12'h123;
        wr_en = 0; rd_en = 0; wr_addr = '0; wr_data = '0; rd_addr = '0;
        rst = 1'b1;
        #1 rst = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_level", fifo_level, 0);
        chk("rst_ready", wr_ready, 1);
        chk("rst_en_we", {bram_en, bram_we, rd_valid, ovf, frame_done}, 0);
        #2 rst = 1'b1;

        // Three queued writes commit in order
        we_log.delete();
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            wr_en = 1; wr_addr = AW'(i); wr_data = DW'(12'hAA1 + i);
        end
        @(negedge clk); wr_en = 0;
        repeat (5) @(negedge clk);
        chk("t1_count", we_log.size(), 3);
        chk("t1_w0", (we_log.size() > 0) ? pk(we_log[0].a, we_log[0].d) : 64'hdead, pk(17'd0, 12'hAA1));
        chk("t1_w1", (we_log.size() > 1) ? pk(we_log[1].a, we_log[1].d) : 64'hdead, pk(17'd1, 12'hAA2));
        chk("t1_w2", (we_log.size() > 2) ? pk(we_log[2].a, we_log[2].d) : 64'hdead, pk(17'd2, 12'hAA3));

        // Reads hold off writes; overflow drops the last two
        we_log.delete();
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            rd_en = 1; rd_addr = AW'(40 + i);
            wr_en = (i < 6); wr_addr = AW'(100 + i); wr_data = DW'(12'hB00 + i);
        end
        @(negedge clk); rd_en = 0; wr_en = 0;
        chk("t2_level", fifo_level, 4);
        chk("t2_ovf", ovf, 1);
        chk("t2_no_we", we_log.size(), 0);
        repeat (6) @(negedge clk);
        chk("t2_drain", we_log.size(), 4);
        for (int i = 0; i < 4; i++)
            if (we_log.size() > i) chk("t2_order", pk(we_log[i].a, we_log[i].d), pk(AW'(100 + i), DW'(12'hB00 + i)));
        if (we_log.size() == 4) chk("t2_consec", we_log[3].c - we_log[0].c, 3);

        // Read latency of two edges
        @(negedge clk); rd_en = 1; rd_addr = 17'd5;
        @(negedge clk); rd_en = 0;
        chk("t3_v_k0", rd_valid, 0);
        @(negedge clk);
        chk("t3_v_k1", rd_valid, 0);
        @(negedge clk);
        chk("t3_v_k2", rd_valid, 1);
        chk("t3_data", rd_data, 12'h123);

        // Steady push+pop at level 2 across pointer wrap
        we_log.delete();
        @(negedge clk); rd_en = 1; wr_en = 1; wr_addr = 17'd200; wr_data = 12'hC00;
        @(negedge clk); wr_addr = 17'd201; wr_data = 12'hC01;
        for (int i = 2; i < 10; i++) begin
            @(negedge clk);
            chk("t4_level", fifo_level, 2);
            rd_en = 0; wr_addr = AW'(200 + i); wr_data = DW'(12'hC00 + i);
        end
        @(negedge clk); wr_en = 0;
        chk("t4_level_end", fifo_level, 2);
        repeat (4) @(negedge clk);
        chk("t4_count", we_log.size(), 10);
        for (int i = 0; i < 10; i++)
            if (we_log.size() > i) chk("t4_order", pk(we_log[i].a, we_log[i].d), pk(AW'(200 + i), DW'(12'hC00 + i)));

        // Last pixel of the frame
        fd_cnt = 0; fd_ok = 0;
        @(negedge clk); wr_en = 1; wr_addr = AW'(FP - 1); wr_data = 12'hFD0;
        @(negedge clk); wr_en = 0;
        repeat (4) @(negedge clk);
        chk("t5_fd_cnt", fd_cnt, 1);
        chk("t5_fd_we", fd_ok, 1);

        // Reset with queued writes and a read in flight
        chk("t6_ovf_sticky", ovf, 1);
        @(negedge clk); rd_en = 1; rd_addr = 17'd7; wr_en = 1; wr_addr = 17'd300; wr_data = 12'hE00;
        @(negedge clk); wr_addr = 17'd301; wr_data = 12'hE01;
        @(negedge clk); wr_addr = 17'd302; wr_data = 12'hE02;
        @(negedge clk); wr_en = 0;
        @(negedge clk); rd_en = 0;
        chk("t6_queued", fifo_level, 3);
        #2 rst = 1'b0;
        @(negedge clk);
        chk("t6_level", fifo_level, 0);
        chk("t6_ready", wr_ready, 1);
        chk("t6_ovf", ovf, 0);
        chk("t6_outs", {bram_en, bram_we, rd_valid, bram_addr, bram_din, rd_data}, 0);
        #2 rst = 1'b1;
        we_log.delete(); rv_cnt = 0;
        repeat (6) @(negedge clk);
        chk("t6_no_we", we_log.size(), 0);
        chk("t6_no_rv", rv_cnt, 0);

        // Randomized traffic with occasional resets
        begin
            int rd_pct = 40;
            for (int n = 0; n < 2500; n++) begin
                @(negedge clk);
                if (n % 100 == 0) rd_pct = $urandom_range(10, 80);
                rd_en   = ($urandom_range(0, 99) < rd_pct);
                wr_en   = ($urandom_range(0, 99) < 55);
                wr_data = DW'($urandom);
                case ($urandom_range(0, 19))
                    0:       wr_addr = AW'(FP - 1);
                    1:       wr_addr = AW'($urandom);
                    default: wr_addr = AW'($urandom_range(0, 15));
                endcase
                rd_addr = ($urandom_range(0, 9) == 0) ? AW'($urandom) : AW'($urandom_range(0, 15));
                if ($urandom_range(0, 299) == 0) begin
                    #2 rst = 1'b0;
                    repeat ($urandom_range(1, 3)) @(negedge clk);
                    #2 rst = 1'b1;
                end
            end
        end
        @(negedge clk); rd_en = 0; wr_en = 0;
        repeat (8) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
